dts_lane_skew_monitor: RTL and testbench

Monitors the 12 per-lane 10 ms metaframe `index` markers leaving the DTS receive chain on the output clock. Each metaframe, it measures the arrival cycle of every lane's marker relative to a reference lane and reports signed per-lane skew, missing lanes, and an aligned flag. Software reads these results and issues the matching offsetter advance/delay commands. The block is observe-only and never touches the data path.

---
 rtl/dts_pkg.sv | 26 ++
 rtl/dts_lane_arrival.sv | 56 +++++
 rtl/dts_lane_skew_monitor.sv | 169 ++++++++++++++++
 tb/tb_dts_lane_skew_monitor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dts_pkg.sv
// -----------------------------------------------------------------------------
// dts_pkg
// Shared definitions for the DTS lane skew monitor: default lane count, the
// measurement FSM state type and the saturating 16-bit increment helper.
// -----------------------------------------------------------------------------
package dts_pkg;

    localparam int N_INPUTS = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        WINDOW = 2'd2,
        REPORT = 2'd3
    } dts_skew_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] dts_skew_sat16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            dts_skew_sat16 = 16'hFFFF;
        end else begin
            dts_skew_sat16 = val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/dts_lane_arrival.sv
// -----------------------------------------------------------------------------
// dts_lane_arrival
// Per-lane arrival recorder. A start pulse clears the lane and records an
// arrival of 0 if the lane has a qualified edge in that same cycle. During the
// capture window only the first qualified edge is recorded (arrival = wcnt_i).
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   edge_i      : rising edge of this lane's metaframe marker
//   mask_i      : lane participates in the measurement
//   start_i     : first marker of a new measurement seen this cycle
//   capture_i   : capture window is open this cycle
//   wcnt_i      : current window cycle count
//   seen_o      : a marker has been recorded for this lane
//   arrival_o   : window cycle of the recorded marker
// -----------------------------------------------------------------------------
module dts_lane_arrival
    import dts_pkg::*;
#(
    parameter int WCNT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              edge_i,
    input  logic              mask_i,
    input  logic              start_i,
    input  logic              capture_i,
    input  logic [WCNT_W-1:0] wcnt_i,
    output logic              seen_o,
    output logic [WCNT_W-1:0] arrival_o
);

    logic              seen_q;
    logic [WCNT_W-1:0] arrival_q;

    // Seen flag and arrival time; later edges on a seen lane are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q    <= 1'b0;
            arrival_q <= '0;
        end else if (start_i) begin
            seen_q    <= edge_i & mask_i;
            arrival_q <= '0;
        end else if (capture_i && mask_i && edge_i && !seen_q) begin
            seen_q    <= 1'b1;
            arrival_q <= wcnt_i;
        end else begin
            seen_q    <= seen_q;
            arrival_q <= arrival_q;
        end
    end

    assign seen_o    = seen_q;
    assign arrival_o = arrival_q;

endmodule

// File: rtl/dts_lane_skew_monitor.sv
// -----------------------------------------------------------------------------
// dts_lane_skew_monitor
// Observe-only monitor of the per-lane 10 ms metaframe markers. The first
// qualified marker opens a MAX_SKEW-cycle window; every lane's first marker in
// the window is timed, and the signed skew of each lane against REF_LANE is
// reported together with missing lanes, an aligned flag and two counters.
//
// Ports:
//   clk, rst_n    : output-domain clock, asynchronous active-low reset
//   enable        : measurement enable (level)
//   lane_mask     : 1 = lane participates (latched when a window opens)
//   index         : per-lane marker level, rising edge = marker
//   skew          : signed per-lane skew, lane i at [i*SKEW_WIDTH +: SKEW_WIDTH]
//   missing       : lane enabled but no marker in the window
//   ref_missing   : reference lane absent or masked in the last measurement
//   aligned       : last measurement fully aligned
//   skew_valid    : one-cycle pulse when the results update
//   meas_cnt      : completed measurements (wrapping)
//   misalign_cnt  : measurements with aligned=0 (saturating)
// -----------------------------------------------------------------------------
module dts_lane_skew_monitor #(
    parameter int N_INPUTS   = dts_pkg::N_INPUTS,
    parameter int MAX_SKEW   = 64,
    parameter int SKEW_WIDTH = 8,
    parameter int REF_LANE   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [N_INPUTS-1:0]            lane_mask,
    input  logic [N_INPUTS-1:0]            index,
    output logic [N_INPUTS*SKEW_WIDTH-1:0] skew,
    output logic [N_INPUTS-1:0]            missing,
    output logic                           ref_missing,
    output logic                           aligned,
    output logic                           skew_valid,
    output logic [15:0]                    meas_cnt,
    output logic [15:0]                    misalign_cnt
);
    import dts_pkg::*;

    localparam int WCNT_W = $clog2(MAX_SKEW + 1);

    dts_skew_state_t state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [N_INPUTS-1:0] index_q;
    logic [N_INPUTS-1:0] mask_r_q;

    logic [N_INPUTS-1:0] edge_s;
    logic [N_INPUTS-1:0] lane_mask_s;
    logic [N_INPUTS-1:0] seen_s;
    logic [WCNT_W-1:0]   arrival_s [N_INPUTS];
    logic [SKEW_WIDTH-1:0] lane_skew_s [N_INPUTS];
    logic [N_INPUTS*SKEW_WIDTH-1:0] skew_s;
    logic [N_INPUTS-1:0] missing_s;
    logic                start_s, capture_s, report_s, ref_miss_s, aligned_s;

    logic [N_INPUTS*SKEW_WIDTH-1:0] skew_q;
    logic [N_INPUTS-1:0] missing_q;
    logic                ref_missing_q, aligned_q, skew_valid_q;
    logic [15:0]         meas_cnt_q, misalign_cnt_q;

    assign edge_s    = index & ~index_q;
    assign start_s   = (state_q == WAIT) & enable & (|(edge_s & lane_mask));
    assign capture_s = (state_q == WINDOW) & enable;
    assign report_s  = (state_q == REPORT) & enable;
    // The live mask qualifies the opening edge; the latched one is used afterwards.
    assign lane_mask_s = (state_q == WAIT) ? lane_mask : mask_r_q;
    assign ref_miss_s  = ~(mask_r_q[REF_LANE] & seen_s[REF_LANE]);

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_lane
        dts_lane_arrival #(.WCNT_W(WCNT_W)) u_arrival (
            .clk       (clk),
            .rst_n     (rst_n),
            .edge_i    (edge_s[g]),
            .mask_i    (lane_mask_s[g]),
            .start_i   (start_s),
            .capture_i (capture_s),
            .wcnt_i    (wcnt_q),
            .seen_o    (seen_s[g]),
            .arrival_o (arrival_s[g])
        );
        assign missing_s[g]   = mask_r_q[g] & ~seen_s[g];
        // Masked, missing or unreferenced lanes report zero skew.
        assign lane_skew_s[g] = (ref_miss_s | ~mask_r_q[g] | ~seen_s[g]) ? '0 :
                                SKEW_WIDTH'(arrival_s[g]) - SKEW_WIDTH'(arrival_s[REF_LANE]);
        assign skew_s[g*SKEW_WIDTH +: SKEW_WIDTH] = lane_skew_s[g];
    end

    assign aligned_s = ~ref_miss_s & ~(|missing_s) & (skew_s == '0);

    // Next-state logic for the measurement FSM and window counter.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT;
                WAIT: begin
                    if (start_s) begin
                        state_d = WINDOW;
                        // The opening cycle is window cycle 0, so the first WINDOW cycle is 1.
                        wcnt_d  = WCNT_W'(1);
                    end else begin
                        state_d = WAIT;
                    end
                end
                WINDOW: begin
                    if (wcnt_q == WCNT_W'(MAX_SKEW)) begin
                        state_d = REPORT;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                REPORT:  state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state, window counter, marker history and latched lane mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            index_q  <= '1;
            mask_r_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            index_q  <= index;
            mask_r_q <= start_s ? lane_mask : mask_r_q;
        end
    end

    // Result registers and counters, updated once per completed measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_q         <= '0;
            missing_q      <= '0;
            ref_missing_q  <= 1'b0;
            aligned_q      <= 1'b0;
            skew_valid_q   <= 1'b0;
            meas_cnt_q     <= 16'd0;
            misalign_cnt_q <= 16'd0;
        end else begin
            skew_valid_q <= report_s;
            if (report_s) begin
                skew_q         <= skew_s;
                missing_q      <= missing_s;
                ref_missing_q  <= ref_miss_s;
                aligned_q      <= aligned_s;
                meas_cnt_q     <= meas_cnt_q + 16'd1;
                misalign_cnt_q <= aligned_s ? misalign_cnt_q : dts_skew_sat16(misalign_cnt_q);
            end
        end
    end

    assign skew         = skew_q;
    assign missing      = missing_q;
    assign ref_missing  = ref_missing_q;
    assign aligned      = aligned_q;
    assign skew_valid   = skew_valid_q;
    assign meas_cnt     = meas_cnt_q;
    assign misalign_cnt = misalign_cnt_q;

endmodule

// File: tb/tb_dts_lane_skew_monitor.sv
module tb_dts_lane_skew_monitor;

    localparam int N  = 12;
    localparam int M  = 64;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [11:0]   lane_mask;
    logic [11:0]   index;
    logic [95:0]   skew;
    logic [11:0]   missing;
    logic          ref_missing, aligned, skew_valid;
    logic [15:0]   meas_cnt, misalign_cnt;

    dts_lane_skew_monitor #(.N_INPUTS(N), .MAX_SKEW(M), .SKEW_WIDTH(SW), .REF_LANE(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lane_mask(lane_mask), .index(index),
        .skew(skew), .missing(missing), .ref_missing(ref_missing), .aligned(aligned),
        .skew_valid(skew_valid), .meas_cnt(meas_cnt), .misalign_cnt(misalign_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int vcnt, vcyc;
    logic [15:0] exp_meas = 16'd0, exp_mis = 16'd0;
    logic [95:0] last_skew = 96'd0;
    logic [11:0] last_missing = 12'd0;
    logic        last_ref = 1'b0, last_al = 1'b0;

    typedef struct {
        logic [11:0] mask;
        int          off [12];
        logic [95:0] skew;
        logic [11:0] missing;
        logic        ref_m;
        logic        al;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Row helper: all lanes pulse at offset 0 except up to two overrides.
    // Expected skew: lane el gets ev, the reference lane 0 gets 0, all others eo.
    task automatic set_row(input int k, input logic [11:0] mask, input int la, input int oa,
                           input int lb, input int ob, input int el, input logic [7:0] ev,
                           input logic [7:0] eo, input logic [11:0] mi, input logic rm,
                           input logic al);
        tbl[k].mask = mask;
        for (int i = 0; i < N; i++) tbl[k].off[i] = 0;
        if (la >= 0) tbl[k].off[la] = oa;
        if (lb >= 0) tbl[k].off[lb] = ob;
        tbl[k].skew = '0;
        for (int i = 0; i < N; i++)
            tbl[k].skew[i*SW +: SW] = (i == el) ? ev : ((i == 0) ? 8'h00 : eo);
        tbl[k].missing = mi;
        tbl[k].ref_m   = rm;
        tbl[k].al      = al;
    endtask

    // Behavioural reference: lane arrivals are offsets from the opening marker at 0.
    task automatic model(input logic [11:0] mask, input int off [12], output logic [95:0] s,
                         output logic [11:0] mi, output logic rm, output logic al);
        bit seen [12];
        for (int i = 0; i < N; i++) seen[i] = mask[i] && off[i] >= 0 && off[i] <= M;
        rm = !seen[0];
        s  = '0;
        mi = '0;
        for (int i = 0; i < N; i++) begin
            mi[i] = mask[i] && !seen[i];
            if (!rm && seen[i]) s[i*SW +: SW] = SW'(off[i] - off[0]);
        end
        al = !rm && (mi == 12'd0) && (s == 96'd0);
    endtask

    // Drives one metaframe: lane i pulses for one cycle at offset off[i] (-1 = never).
    task automatic run_frame(input logic [11:0] mask, input int off [12], input int drop_at,
                             input int rst_at);
        vcnt = 0;
        vcyc = -1;
        lane_mask = mask;
        enable = 1'b1;
        index = 12'h000;
        repeat (2) @(negedge clk);
        for (int c = 0; c <= M + 4; c++) begin
            @(negedge clk);
            if (skew_valid) begin
                vcnt++;
                vcyc = c;
            end
            if (c == drop_at) enable = 1'b0;
            if (c == rst_at) rst_n = 1'b0;
            else if (rst_at >= 0 && c == rst_at + 1) rst_n = 1'b1;
            for (int i = 0; i < N; i++) index[i] = (off[i] == c);
        end
        index = 12'h000;
    endtask

    task automatic check_frame(input string tag, input logic [95:0] s, input logic [11:0] mi,
                               input logic rm, input logic al);
        chk({tag, " valid_pulses"}, 96'(vcnt), 96'd1);
        chk({tag, " valid_cycle"}, 96'(vcyc), 96'(M + 2));
        chk({tag, " skew"}, skew, s);
        chk({tag, " missing"}, 96'(missing), 96'(mi));
        chk({tag, " ref_missing"}, 96'(ref_missing), 96'(rm));
        chk({tag, " aligned"}, 96'(aligned), 96'(al));
        exp_meas = exp_meas + 16'd1;
        if (!al) exp_mis = (exp_mis == 16'hFFFF) ? 16'hFFFF : exp_mis + 16'd1;
        chk({tag, " meas_cnt"}, 96'(meas_cnt), 96'(exp_meas));
        chk({tag, " misalign_cnt"}, 96'(misalign_cnt), 96'(exp_mis));
        last_skew = s;
        last_missing = mi;
        last_ref = rm;
        last_al = al;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " skew"}, skew, 96'd0);
        chk({tag, " missing"}, 96'(missing), 96'd0);
        chk({tag, " ref_missing"}, 96'(ref_missing), 96'd0);
        chk({tag, " aligned"}, 96'(aligned), 96'd0);
        chk({tag, " skew_valid"}, 96'(skew_valid), 96'd0);
        chk({tag, " meas_cnt"}, 96'(meas_cnt), 96'd0);
        chk({tag, " misalign_cnt"}, 96'(misalign_cnt), 96'd0);
    endtask

    initial begin : main
        int          zeros [12];
        int          off [12];
        logic [95:0] es;
        logic [11:0] emi;
        logic        erm, eal;
        int          pulses;

        for (int i = 0; i < N; i++) zeros[i] = 0;
        set_row(0, 12'hFFF, -1,  0, -1,  0,  0, 8'h00, 8'h00, 12'h000, 1'b0, 1'b1);
        set_row(1, 12'hFFF,  5,  3, -1,  0,  5, 8'h03, 8'h00, 12'h000, 1'b0, 1'b0);
        set_row(2, 12'hFFF,  0,  2, -1,  0,  0, 8'h00, 8'hFE, 12'h000, 1'b0, 1'b0);
        set_row(3, 12'hFF7,  7, -1,  3, 10,  0, 8'h00, 8'h00, 12'h080, 1'b0, 1'b0);
        set_row(4, 12'hFFE, -1,  0, -1,  0,  0, 8'h00, 8'h00, 12'h000, 1'b1, 1'b0);
        set_row(5, 12'hFFF, 11, 64, -1,  0, 11, 8'h40, 8'h00, 12'h000, 1'b0, 1'b0);
        set_row(6, 12'hFFF, 11, 65, -1,  0,  0, 8'h00, 8'h00, 12'h800, 1'b0, 1'b0);
        set_row(7, 12'hFFF,  0, 64, -1,  0,  0, 8'h00, 8'hC0, 12'h000, 1'b0, 1'b0);

        // Reset held with all markers already high.
        rst_n = 1'b0;
        enable = 1'b1;
        lane_mask = 12'hFFF;
        index = 12'hFFF;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < M + 16; c++) begin
            @(negedge clk);
            if (skew_valid) pulses++;
        end
        chk("held_high pulses", 96'(pulses), 96'd0);
        chk("held_high meas_cnt", 96'(meas_cnt), 96'd0);

        // Directed table.
        for (int k = 0; k < 8; k++) begin
            run_frame(tbl[k].mask, tbl[k].off, -1, -1);
            check_frame($sformatf("row%0d", k), tbl[k].skew, tbl[k].missing, tbl[k].ref_m, tbl[k].al);
        end

        // enable dropped mid-window: no report, outputs hold.
        run_frame(12'hFFF, zeros, 20, -1);
        chk("drop valid_pulses", 96'(vcnt), 96'd0);
        chk("drop skew", skew, last_skew);
        chk("drop missing", 96'(missing), 96'(last_missing));
        chk("drop aligned", 96'(aligned), 96'(last_al));
        chk("drop meas_cnt", 96'(meas_cnt), 96'(exp_meas));
        run_frame(12'hFFF, zeros, -1, -1);
        check_frame("after_drop", 96'd0, 12'd0, 1'b0, 1'b1);

        // Randomised frames against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [11:0] msk;
            int          l;
            int          mode;
            msk  = 12'($urandom_range(1, 4095));
            mode = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                if (mode == 0) off[i] = 0;
                else if ($urandom_range(0, 4) == 0) off[i] = -1;
                else off[i] = $urandom_range(0, M + 1);
            end
            do l = $urandom_range(0, N - 1); while (!msk[l]);
            off[l] = 0;
            model(msk, off, es, emi, erm, eal);
            run_frame(msk, off, -1, -1);
            check_frame($sformatf("rand%0d", r), es, emi, erm, eal);
        end

        // Counter wrap and saturation from preloaded counts.
        @(negedge clk);
        force dut.meas_cnt_q = 16'hFFFF;
        force dut.misalign_cnt_q = 16'hFFFF;
        #1;
        release dut.meas_cnt_q;
        release dut.misalign_cnt_q;
        exp_meas = 16'hFFFF;
        exp_mis = 16'hFFFF;
        run_frame(tbl[1].mask, tbl[1].off, -1, -1);
        check_frame("wrap0", tbl[1].skew, tbl[1].missing, tbl[1].ref_m, tbl[1].al);
        run_frame(tbl[1].mask, tbl[1].off, -1, -1);
        check_frame("wrap1", tbl[1].skew, tbl[1].missing, tbl[1].ref_m, tbl[1].al);

        // Reset mid-window aborts the measurement.
        run_frame(tbl[1].mask, tbl[1].off, -1, 30);
        chk("midrst valid_pulses", 96'(vcnt), 96'd0);
        check_reset_values("midrst");
        exp_meas = 16'd0;
        exp_mis = 16'd0;
        run_frame(12'hFFF, zeros, -1, -1);
        check_frame("after_rst", 96'd0, 12'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
